// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Package : pe_pkg
//  Purpose : Shared widths, field positions and the result-word type used by
//            the PE-array result path (PE tree -> leaf_result_collector).
//  Ports   : n/a (package)
//  Rev     : 1.0  initial release
// ============================================================================
package pe_pkg;

   localparam int PKT_W    = 201;              // full PE-tree packet width
   localparam int ADDR_W   = 3;                // leaf address; 0 = null address
   localparam int NUCL_W   = 32;               // 16 bases x 2 bits
   localparam int RES_W    = ADDR_W + NUCL_W;  // one result word

   // Result word field slices: {address, nucl_alig}
   localparam int ADDR_MSB = RES_W - 1;
   localparam int ADDR_LSB = NUCL_W;
   localparam int NUCL_MSB = NUCL_W - 1;
   localparam int NUCL_LSB = 0;

   // Control bits at the top of the PE-tree packet
   localparam int CH1      = PKT_W - 3;        // child 1 valid
   localparam int CH2      = PKT_W - 2;        // child 2 valid
   localparam int MATP     = PKT_W - 1;        // match-pair flag

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [NUCL_W-1:0] nucl;
   } res_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : sync_fifo
//  Purpose : Single-clock show-ahead FIFO; dout always presents the head entry.
//            A push into a full FIFO is accepted only together with a pop.
//  Ports   : clk, reset (async, active-low), clear (sync flush),
//            push/din, pop/dout, full, empty, count
//  Rev     : 1.0  initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only entries between the pointers are ever read out.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/leaf_result_collector.sv
`default_nettype none
// ============================================================================
//  Module  : leaf_result_collector
//  Purpose : Detects new result words on NUM_PE PE ports, round-robin
//            arbitrates them into a show-ahead FIFO, streams them to the host
//            over valid/ready and tracks per-leaf completion.
//  Ports   : clk, reset (async, active-low), clear (sync new-run pulse)
//            result_in  - NUM_PE packed {addr, nucl} words, 0 = none
//            leaf_mask  - leaves expected this run (bit 0 ignored)
//            out_valid/out_ready/out_addr/out_data/out_idx/out_last - host stream
//            leaf_done, all_done, err_ovf, err_addr - run status
//  Rev     : 1.0  initial release
// ============================================================================
module leaf_result_collector
   import pe_pkg::*;
#(
   parameter int NUM_PE         = 4,
   parameter int WORDS_PER_LEAF = 8,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              clear,
   input  logic [NUM_PE*RES_W-1:0]           result_in,
   input  logic [2**ADDR_W-1:0]              leaf_mask,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [ADDR_W-1:0]                 out_addr,
   output logic [NUCL_W-1:0]                 out_data,
   output logic [$clog2(WORDS_PER_LEAF)-1:0] out_idx,
   output logic                              out_last,
   output logic [2**ADDR_W-1:0]              leaf_done,
   output logic                              all_done,
   output logic                              err_ovf,
   output logic                              err_addr
);

   localparam int NL = 2**ADDR_W;
   localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam int IW = $clog2(WORDS_PER_LEAF);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   res_t              cur  [NUM_PE];
   res_t              prev [NUM_PE];
   res_t              pend [NUM_PE];
   logic [NUM_PE-1:0] pend_v;
   logic [NUM_PE-1:0] evt;
   logic [NUM_PE-1:0] bad_addr;
   logic [NUM_PE-1:0] granted;
   logic [PW-1:0]     last_grant;
   logic [PW-1:0]     gnt_idx;
   logic              gnt_v;
   logic              ovf_hit;

   logic              pop;
   logic              can_push;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_level_unused;
   res_t              head;

   logic [IW-1:0]     cnt [NL];
   logic [NL-1:0]     mask_eff;

   // ---------------------------------------------------------------- detect
   generate
      for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_port
         assign cur[gi]      = result_in[gi*RES_W +: RES_W];
         // A held word matches prev, so it only fires on the cycle it appears.
         assign evt[gi]      = (cur[gi] != '0) && (cur[gi] != prev[gi]);
         assign bad_addr[gi] = evt[gi] && (cur[gi].addr == '0);
         assign granted[gi]  = gnt_v && (gnt_idx == PW'(gi));
      end
   endgenerate

   // A port overflows only if its slot is occupied and not being drained now.
   assign ovf_hit = |(evt & ~bad_addr & pend_v & ~granted);

   // ---------------------------------------------------------------- arbiter
   assign pop      = out_valid && out_ready;
   assign can_push = !fifo_full || pop;

   always_comb begin : p_arb
      logic [PW-1:0] cand;
      gnt_v   = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      if (can_push) begin
         for (int j = 1; j <= NUM_PE; j++) begin
            cand = PW'((int'(last_grant) + j) % NUM_PE);
            if (!gnt_v && pend_v[cand]) begin
               gnt_v   = 1'b1;
               gnt_idx = cand;
            end
         end
      end
   end

   // ------------------------------------------------- pending slots / errors
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_v     <= '0;
         // First search after reset begins at port 0.
         last_grant <= PW'(NUM_PE - 1);
         err_ovf    <= 1'b0;
         err_addr   <= 1'b0;
         for (int i = 0; i < NUM_PE; i++) begin
            prev[i] <= '0;
            pend[i] <= '0;
         end
      end else begin
         // prev tracks the inputs even during clear so held words stay quiet.
         for (int i = 0; i < NUM_PE; i++) prev[i] <= cur[i];
         if (clear) begin
            pend_v   <= '0;
            err_ovf  <= 1'b0;
            err_addr <= 1'b0;
         end else begin
            for (int i = 0; i < NUM_PE; i++) begin
               if (evt[i] && !bad_addr[i] && (!pend_v[i] || granted[i])) begin
                  pend[i]   <= cur[i];
                  pend_v[i] <= 1'b1;
               end else if (granted[i]) begin
                  pend_v[i] <= 1'b0;
               end
            end
            if (gnt_v)     last_grant <= gnt_idx;
            if (|bad_addr) err_addr   <= 1'b1;
            if (ovf_hit)   err_ovf    <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- buffer
   sync_fifo #(
      .WIDTH (RES_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .push  (gnt_v && !clear),
      .din   (pend[gnt_idx]),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_level_unused)
   );

   // Fields read as zero when idle so the stream is fully defined out of reset.
   assign out_valid = !fifo_empty;
   assign out_addr  = out_valid ? head.addr : '0;
   assign out_data  = out_valid ? head.nucl : '0;
   assign out_idx   = cnt[out_addr];
   assign out_last  = out_valid && (out_idx == IW'(WORDS_PER_LEAF - 1));

   // ------------------------------------------------------ leaf completion
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         leaf_done <= '0;
         for (int a = 0; a < NL; a++) cnt[a] <= '0;
      end else if (clear) begin
         leaf_done <= '0;
         for (int a = 0; a < NL; a++) cnt[a] <= '0;
      end else if (pop) begin
         if (out_last) begin
            cnt[out_addr]       <= '0;
            leaf_done[out_addr] <= 1'b1;
         end else begin
            cnt[out_addr] <= cnt[out_addr] + 1'b1;
         end
      end
   end

   assign mask_eff = leaf_mask & ~NL'(1);
   assign all_done = (mask_eff != '0) && ((leaf_done & mask_eff) == mask_eff);

endmodule
`default_nettype wire

// File: tb/tb_leaf_result_collector.sv
`default_nettype none
// ============================================================================
//  Module  : tb_leaf_result_collector
//  Purpose : Self-checking bench for leaf_result_collector. Expected words
//            are queued as stimulus is applied and compared as the host
//            interface accepts them.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_leaf_result_collector;

   logic          clk = 1'b0;
   logic          reset;
   logic          clear;
   logic [139:0]  result_in;
   logic [7:0]    leaf_mask;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    out_addr;
   logic [31:0]   out_data;
   logic [2:0]    out_idx;
   logic          out_last;
   logic [7:0]    leaf_done;
   logic          all_done;
   logic          err_ovf;
   logic          err_addr;

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] data;
      logic [2:0]  idx;
      logic        last;
   } exp_t;

   exp_t       sb [$];
   exp_t       mon_e;
   logic [2:0] m_cnt [8];
   int         checks = 0;
   int         errors = 0;
   int         pops   = 0;

   always #5 clk = ~clk;

   leaf_result_collector dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .result_in (result_in),
      .leaf_mask (leaf_mask),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .leaf_done (leaf_done),
      .all_done  (all_done),
      .err_ovf   (err_ovf),
      .err_addr  (err_addr)
   );

   // ------------------------------------------------------------ stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic [2:0] a, input logic [31:0] d);
      result_in[p*35 +: 35] = {a, d};
   endtask

   task automatic model_reset();
      for (int a = 0; a < 8; a++) m_cnt[a] = 3'd0;
   endtask

   task automatic sb_push(input logic [2:0] a, input logic [31:0] d);
      exp_t e;
      e.addr   = a;
      e.data   = d;
      e.idx    = m_cnt[a];
      e.last   = (m_cnt[a] == 3'd7);
      m_cnt[a] = m_cnt[a] + 3'd1;
      sb.push_back(e);
   endtask

   // ------------------------------------------------------------ scoreboard
   always @(negedge clk) begin
      if (reset && !clear && out_valid && out_ready) begin
         pops++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL word_unexpected got addr=%0d data=%h idx=%0d required no word",
                     out_addr, out_data, out_idx);
         end else begin
            mon_e = sb.pop_front();
            if (out_addr !== mon_e.addr || out_data !== mon_e.data ||
                out_idx !== mon_e.idx || out_last !== mon_e.last) begin
               errors++;
               $display("FAIL word got a=%0d d=%h i=%0d l=%b required a=%0d d=%h i=%0d l=%b",
                        out_addr, out_data, out_idx, out_last,
                        mon_e.addr, mon_e.data, mon_e.idx, mon_e.last);
            end
         end
      end
   end

   // ------------------------------------------------------------ tests
   task automatic test_reset();
      reset = 1'b0; clear = 1'b0; result_in = '0; leaf_mask = 8'h00; out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out_last, all_done, err_ovf, err_addr} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b required 00000",
                  {out_valid, out_last, all_done, err_ovf, err_addr});
      end
      checks++;
      if (out_addr !== 3'd0 || out_data !== 32'd0 || out_idx !== 3'd0) begin
         errors++;
         $display("FAIL reset_fields got a=%0d d=%h i=%0d required 0", out_addr, out_data, out_idx);
      end
      checks++;
      if (leaf_done !== 8'h00) begin
         errors++;
         $display("FAIL reset_leaf_done got %h required 00", leaf_done);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int base;
      base      = pops;
      out_ready = 1'b1;
      set_port(3, 3'd3, 32'hDEADBEEF);
      sb_push(3'd3, 32'hDEADBEEF);
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_latency_early got out_valid=%b required 0", out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_addr !== 3'd3 || out_data !== 32'hDEADBEEF || out_idx !== 3'd0) begin
         errors++;
         $display("FAIL single_word got v=%b a=%0d d=%h i=%0d required v=1 a=3 d=deadbeef i=0",
                  out_valid, out_addr, out_data, out_idx);
      end
      repeat (3) @(posedge clk);
      #1;
      set_port(3, 3'd0, 32'd0);
      repeat (6) tick();
      checks++;
      if (pops - base != 1 || sb.size() != 0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_count got pops=%0d left=%0d v=%b required pops=1 left=0 v=0",
                  pops - base, sb.size(), out_valid);
      end
   endtask

   task automatic test_round_robin();
      int base;
      base      = pops;
      out_ready = 1'b1;
      for (int burst = 0; burst < 2; burst++) begin
         if (burst == 1) tick();
         for (int i = 0; i < 4; i++) begin
            set_port(i, 3'(i + 1), 32'hB100_0000 + 32'(burst * 32'h0010_0000) + 32'(i));
            sb_push(3'(i + 1), 32'hB100_0000 + 32'(burst * 32'h0010_0000) + 32'(i));
         end
         repeat (2) @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_latency burst %0d got out_valid=%b required 0", burst, out_valid);
         end
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_addr !== 3'(i + 1)) begin
               errors++;
               $display("FAIL rr_order burst %0d slot %0d got v=%b a=%0d required v=1 a=%0d",
                        burst, i, out_valid, out_addr, i + 1);
            end
         end
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain burst %0d got out_valid=%b required 0", burst, out_valid);
         end
      end
      tick();
      result_in = '0;
      repeat (3) tick();
      checks++;
      if (pops - base != 8 || sb.size() != 0) begin
         errors++;
         $display("FAIL rr_count got pops=%0d left=%0d required pops=8 left=0", pops - base, sb.size());
      end
   endtask

   task automatic test_back_pressure();
      int          base;
      logic [31:0] held;
      base      = pops;
      out_ready = 1'b0;
      for (int n = 0; n < 10; n++) begin
         set_port(0, 3'd5, 32'h0000_1000 + 32'(n));
         if (n < 9) sb_push(3'd5, 32'h0000_1000 + 32'(n));
         repeat (2) tick();
      end
      checks++;
      if (err_ovf !== 1'b1) begin
         errors++;
         $display("FAIL bp_err_ovf got %b required 1", err_ovf);
      end
      checks++;
      if (out_valid !== 1'b1 || out_addr !== 3'd5 || out_data !== 32'h0000_1000 || out_idx !== 3'd0) begin
         errors++;
         $display("FAIL bp_head got v=%b a=%0d d=%h i=%0d required v=1 a=5 d=00001000 i=0",
                  out_valid, out_addr, out_data, out_idx);
      end
      held = out_data;
      repeat (3) tick();
      checks++;
      if (out_data !== held || out_addr !== 3'd5 || out_valid !== 1'b1 || pops != base) begin
         errors++;
         $display("FAIL bp_stable got v=%b a=%0d d=%h pops=%0d required v=1 a=5 d=%h pops=0",
                  out_valid, out_addr, out_data, pops - base, held);
      end
      set_port(0, 3'd0, 32'd0);
      out_ready = 1'b1;
      repeat (14) tick();
      checks++;
      if (pops - base != 9 || sb.size() != 0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain got pops=%0d left=%0d v=%b required pops=9 left=0 v=0",
                  pops - base, sb.size(), out_valid);
      end
   endtask

   task automatic test_leaf_done();
      bit found;
      clear = 1'b1;
      model_reset();
      tick();
      clear = 1'b0;
      checks++;
      if (leaf_done !== 8'h00 || err_ovf !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL clear_state got done=%h ovf=%b v=%b required 00 0 0", leaf_done, err_ovf, out_valid);
      end
      leaf_mask = 8'h06;
      #1;
      checks++;
      if (all_done !== 1'b0) begin
         errors++;
         $display("FAIL leaf_all_done_early got %b required 0", all_done);
      end
      out_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         set_port(1, 3'd1, 32'hA100_0000 + 32'(n));
         set_port(2, 3'd2, 32'hA200_0000 + 32'(n));
         sb_push(3'd1, 32'hA100_0000 + 32'(n));
         sb_push(3'd2, 32'hA200_0000 + 32'(n));
         repeat (2) tick();
      end
      found = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (out_valid && out_addr == 3'd2 && out_last) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL leaf_last_timeout got no addr2 last word required one within 12 cycles");
      end
      checks++;
      if (all_done !== 1'b0 || leaf_done !== 8'h02) begin
         errors++;
         $display("FAIL leaf_before_pop got all=%b done=%h required all=0 done=02", all_done, leaf_done);
      end
      @(posedge clk);
      #1;
      checks++;
      if (all_done !== 1'b1 || leaf_done !== 8'h06) begin
         errors++;
         $display("FAIL leaf_after_pop got all=%b done=%h required all=1 done=06", all_done, leaf_done);
      end
      leaf_mask = 8'h07;
      #1;
      checks++;
      if (all_done !== 1'b1) begin
         errors++;
         $display("FAIL mask_bit0_ignored got %b required 1", all_done);
      end
      leaf_mask = 8'h00;
      #1;
      checks++;
      if (all_done !== 1'b0) begin
         errors++;
         $display("FAIL mask_zero got %b required 0", all_done);
      end
      leaf_mask = 8'h06;
      result_in = '0;
      repeat (3) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL leaf_left got %0d words required 0", sb.size());
      end
   endtask

   task automatic test_reset_midstream();
      int base;
      base      = pops;
      out_ready = 1'b0;
      set_port(0, 3'd1, 32'hC000_0000);
      set_port(1, 3'd2, 32'hC000_0001);
      set_port(2, 3'd3, 32'hC000_0002);
      repeat (5) tick();
      checks++;
      if (out_valid !== 1'b1 || leaf_done !== 8'h06) begin
         errors++;
         $display("FAIL midrst_before got v=%b done=%h required v=1 done=06", out_valid, leaf_done);
      end
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || leaf_done !== 8'h00 || all_done !== 1'b0) begin
         errors++;
         $display("FAIL midrst_immediate got v=%b done=%h all=%b required 0 00 0",
                  out_valid, leaf_done, all_done);
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      sb_push(3'd1, 32'hC000_0000);
      sb_push(3'd2, 32'hC000_0001);
      sb_push(3'd3, 32'hC000_0002);
      out_ready = 1'b1;
      repeat (8) tick();
      checks++;
      if (pops - base != 3 || sb.size() != 0) begin
         errors++;
         $display("FAIL midrst_reemit got pops=%0d left=%0d required pops=3 left=0", pops - base, sb.size());
      end
      result_in = '0;
      tick();
   endtask

   task automatic test_addr0_and_clear();
      int base;
      base      = pops;
      out_ready = 1'b1;
      set_port(0, 3'd0, 32'h1234_5678);
      repeat (4) tick();
      checks++;
      if (err_addr !== 1'b1 || out_valid !== 1'b0 || err_ovf !== 1'b0 || pops != base) begin
         errors++;
         $display("FAIL addr0 got err_addr=%b v=%b ovf=%b pops=%0d required 1 0 0 0",
                  err_addr, out_valid, err_ovf, pops - base);
      end
      clear = 1'b1;
      set_port(1, 3'd3, 32'hCAFE_0001);
      tick();
      clear = 1'b0;
      model_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_event_dropped cycle %0d got out_valid=%b required 0", c, out_valid);
         end
      end
      checks++;
      if (err_addr !== 1'b0 || err_ovf !== 1'b0 || leaf_done !== 8'h00 || pops != base) begin
         errors++;
         $display("FAIL clear_flags got addr=%b ovf=%b done=%h pops=%0d required 0 0 00 0",
                  err_addr, err_ovf, leaf_done, pops - base);
      end
      result_in = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_back_pressure();
      test_leaf_done();
      test_reset_midstream();
      test_addr0_and_clear();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
